// File: rtl/regfile_dump.sv
// Walks a register-file read port from FIRST_REG to LAST_REG and streams each value out
// as a valid/ready beat. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_sum,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, READ, HOLD, SUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
`endif

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [IDX_W-1:0]    out_index_q;
    logic                out_last_q;
    logic                busy_q;
    logic                done_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
    logic                out_sum_q;
`endif

    // Increment only taken while idx_q < LAST_IDX, so the counter cannot wrap.
    assign idx_d = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= '0;
            out_sum_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= READ;
                        idx_q   <= FIRST_IDX;
                        busy_q  <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                READ: begin
                    out_data_q  <= rf_data;
                    out_index_q <= idx_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last_q  <= 1'b0;
`else
                    out_last_q  <= (idx_q == LAST_IDX);
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        csum_q <= csum_q ^ out_data_q;
`endif
                        if (idx_q < LAST_IDX) begin
                            idx_q       <= idx_d;
                            out_valid_q <= 1'b0;
                            state_q     <= READ;
                        end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                            // Sum beat folds in the final register value being accepted now.
                            out_data_q  <= csum_q ^ out_data_q;
                            out_index_q <= '0;
                            out_sum_q   <= 1'b1;
                            out_last_q  <= 1'b1;
                            state_q     <= SUM;
`else
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
`endif
                        end
                    end
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                SUM: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sum_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    assign out_sum   = out_sum_q;
`else
    assign out_sum   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full dump, backpressure, ignored start, mid-dump reset,
// single-register build, and the checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module tb_regfile_dump;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, out_ready, start_a, start_b, start_c;
    logic [4:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [31:0] rf_data_a, rf_data_b, rf_data_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;
    logic [4:0]  out_index_a, out_index_b, out_index_c;
    logic        out_sum_a, out_sum_b, out_sum_c;
    logic        out_last_a, out_last_b, out_last_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    // Register-file models: x0 reads 0, xi reads 0x100+i; instance c uses its own table.
    assign rf_data_a = (rf_addr_a == 5'd0) ? 32'd0 : 32'h100 + 32'(rf_addr_a);
    assign rf_data_b = (rf_addr_b == 5'd0) ? 32'd0 : 32'h100 + 32'(rf_addr_b);
    assign rf_data_c = (rf_addr_c == 5'd1) ? 32'hF0 :
                       (rf_addr_c == 5'd2) ? 32'h0F :
                       (rf_addr_c == 5'd3) ? 32'hFF : 32'h0;

    regfile_dump u_dut (
        .clk(clk), .reset(reset), .start(start_a), .rf_addr(rf_addr_a), .rf_data(rf_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_index(out_index_a), .out_sum(out_sum_a), .out_last(out_last_a),
        .busy(busy_a), .done(done_a)
    );

    regfile_dump #(.FIRST_REG(7), .LAST_REG(7)) u_dut_one (
        .clk(clk), .reset(reset), .start(start_b), .rf_addr(rf_addr_b), .rf_data(rf_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_index(out_index_b), .out_sum(out_sum_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b)
    );

    regfile_dump #(.FIRST_REG(1), .LAST_REG(3)) u_dut_sum (
        .clk(clk), .reset(reset), .start(start_c), .rf_addr(rf_addr_c), .rf_data(rf_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .out_index(out_index_c), .out_sum(out_sum_c), .out_last(out_last_c),
        .busy(busy_c), .done(done_c)
    );

    int n_vec = 0;
    int n_err = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int done_cnt_c = 0;

    always @(posedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic valid_of(input int sel);
        return (sel == 0) ? out_valid_a : (sel == 1) ? out_valid_b : out_valid_c;
    endfunction

    // Bounded wait (sampled on negedge) for out_valid of the selected instance.
    task automatic wait_valid(input int sel, output int cyc);
        cyc = 0;
        while (!valid_of(sel) && cyc < 16) begin
            @(negedge clk);
            cyc++;
        end
        if (!valid_of(sel)) check_eq("valid_timeout", 32'(valid_of(sel)), 32'd1);
    endtask

    task automatic run_dump_a(input int stall_idx, input int poke_idx, input int abort_idx);
        int          cyc;
        int          d0;
        logic [31:0] exp_d;
        logic [31:0] sum_m;
        d0        = done_cnt_a;
        sum_m     = 32'd0;
        out_ready = 1'b1;
        start_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("read_busy", 32'(busy_a), 32'd1);
        check_eq("read_no_valid", 32'(out_valid_a), 32'd0);
        for (int i = 0; i < 32; i++) begin
            wait_valid(0, cyc);
            check_eq("beat_gap", 32'(cyc), 32'd1);
            exp_d = (i == 0) ? 32'd0 : 32'h100 + 32'(i);
            sum_m = sum_m ^ exp_d;
            check_eq("beat_index", 32'(out_index_a), 32'(i));
            check_eq("beat_data", out_data_a, exp_d);
            check_eq("beat_last", 32'(out_last_a), 32'((i == 31) && !CSUM));
            check_eq("beat_sum", 32'(out_sum_a), 32'd0);
            if (i == abort_idx) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq("abort_valid", 32'(out_valid_a), 32'd0);
                check_eq("abort_busy", 32'(busy_a), 32'd0);
                check_eq("abort_index", 32'(out_index_a), 32'd0);
                repeat (4) @(negedge clk);
                check_eq("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
                return;
            end
            if (i == stall_idx) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("stall_valid", 32'(out_valid_a), 32'd1);
                    check_eq("stall_data", out_data_a, exp_d);
                    check_eq("stall_index", 32'(out_index_a), 32'(i));
                end
                out_ready = 1'b1;
            end
            if (i == poke_idx) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        if (CSUM) begin
            wait_valid(0, cyc);
            check_eq("sum_data", out_data_a, sum_m);
            check_eq("sum_flag", 32'(out_sum_a), 32'd1);
            check_eq("sum_last", 32'(out_last_a), 32'd1);
            check_eq("sum_index", 32'(out_index_a), 32'd0);
            @(negedge clk);
        end
        check_eq("done_pulse", 32'(done_a), 32'd1);
        check_eq("done_idle", 32'(busy_a), 32'd0);
        check_eq("done_no_valid", 32'(out_valid_a), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("done_count", 32'(done_cnt_a - d0), 32'd1);
        check_eq("stay_idle", 32'(busy_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int d0;
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid_a), 32'd0);
        check_eq("rst_data", out_data_a, 32'd0);
        check_eq("rst_index", 32'(out_index_a), 32'd0);
        check_eq("rst_last", 32'(out_last_a), 32'd0);
        check_eq("rst_sum", 32'(out_sum_a), 32'd0);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_addr", 32'(rf_addr_a), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_no_start", 32'(busy_a), 32'd0);

        run_dump_a(-1, -1, -1);
        run_dump_a(3, 5, -1);
        run_dump_a(-1, -1, 10);
        run_dump_a(-1, -1, -1);

        // Single-register build.
        d0      = done_cnt_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_valid(1, cyc);
        check_eq("one_gap", 32'(cyc), 32'd1);
        check_eq("one_index", 32'(out_index_b), 32'd7);
        check_eq("one_data", out_data_b, 32'h107);
        check_eq("one_last", 32'(out_last_b), 32'(!CSUM));
        @(negedge clk);
        if (CSUM) begin
            wait_valid(1, cyc);
            check_eq("one_sum_data", out_data_b, 32'h107);
            check_eq("one_sum_flag", 32'(out_sum_b), 32'd1);
            @(negedge clk);
        end
        check_eq("one_done", 32'(done_b), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("one_done_count", 32'(done_cnt_b - d0), 32'd1);

        if (CSUM) begin
            d0      = done_cnt_c;
            start_c = 1'b1;
            @(negedge clk);
            start_c = 1'b0;
            for (int i = 1; i <= 3; i++) begin
                wait_valid(2, cyc);
                check_eq("cs_index", 32'(out_index_c), 32'(i));
                check_eq("cs_last", 32'(out_last_c), 32'd0);
                @(negedge clk);
            end
            wait_valid(2, cyc);
            check_eq("cs_sum_data", out_data_c, 32'h0);
            check_eq("cs_sum_flag", 32'(out_sum_c), 32'd1);
            check_eq("cs_sum_last", 32'(out_last_c), 32'd1);
            check_eq("cs_sum_index", 32'(out_index_c), 32'd0);
            @(negedge clk);
            check_eq("cs_done", 32'(done_c), 32'd1);
            repeat (2) @(negedge clk);
            check_eq("cs_done_count", 32'(done_cnt_c - d0), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter FIRST_REG, default 0, SHALL be the first register index dumped (0..31).
REQ-003 Parameter LAST_REG, default 31, SHALL be the last register index dumped (FIRST_REG..31).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to begin a dump; sampled only in IDLE.
REQ-007 rf_addr  output  5  read address driven to a register-file read port.
REQ-008 rf_data  input  32  combinational read data returned for rf_addr.
REQ-009 out_valid  output  1  out_data, out_index and out_sum hold a beat.
REQ-010 out_ready  input  1  consumer accepts the beat when high with out_valid.
REQ-011 out_data  output  32  register value, or checksum on a sum beat.
REQ-012 out_index  output  5  register index of the beat; 0 on a sum beat.
REQ-013 out_sum  output  1  current beat is the checksum beat.
REQ-014 out_last  output  1  current beat is the final beat of the dump.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after the final beat transfers.

Function
REQ-017 The FSM SHALL have states IDLE, READ, HOLD and SUM, with SUM present only when the macro in REQ-031 is defined.
REQ-018 In IDLE with start=1, the next state SHALL be READ, and the index counter SHALL load FIRST_REG.
REQ-019 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-020 In READ, rf_addr SHALL equal the index counter, and at the clock edge rf_data SHALL be captured into out_data, the index into out_index, and the state SHALL become HOLD.
REQ-021 out_valid SHALL be 1 exactly in HOLD and SUM.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_index, out_sum and out_last SHALL be held stable.
REQ-023 A transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-024 On a HOLD transfer with index < LAST_REG, the index SHALL increment by 1 and the state SHALL become READ.
REQ-025 On a HOLD transfer with index = LAST_REG, the state SHALL become SUM if enabled; otherwise it SHALL become IDLE with done=1 for the following cycle.
REQ-026 Latency SHALL be 2 cycles from start sampled to the first out_valid, and each beat SHALL take a minimum of 2 cycles (READ+HOLD).
REQ-027 start asserted while busy=1 SHALL be ignored.
REQ-028 When FIRST_REG = LAST_REG, exactly one register beat SHALL be produced.
REQ-029 rf_addr SHALL equal the index counter in all states, and the index counter SHALL never wrap past 31.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL enter IDLE with out_valid=0, out_data=0, out_index=0, out_sum=0, out_last=0, busy=0, done=0, the index counter=0 and the checksum=0; a reset mid-dump SHALL abort the dump without a done pulse.

Configuration
REQ-031 With REGFILE_DUMP_CHECKSUM_EN defined, the block SHALL XOR every transferred register value into a 32-bit checksum (cleared on start), and after the LAST_REG beat it SHALL emit one SUM beat with out_data=checksum, out_index=0, out_sum=1 and out_last=1, then assert done and return to IDLE.
REQ-032 Without REGFILE_DUMP_CHECKSUM_EN, the block SHALL have no SUM state or checksum register, out_sum SHALL be tied 0, and out_last SHALL be 1 on the LAST_REG beat.

Verification
REQ-033 Basic dump: defaults, model x1..x31 = 0x100+i, out_ready=1, pulse start -> 32 beats index 0..31 with data 0, 0x101..0x11F; done pulses exactly once; first out_valid 2 cycles after start.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles on beat index 3 -> out_data=0x103 and out_index=3 held stable, no beat lost or duplicated.
REQ-035 Checksum (macro defined): FIRST_REG=1, LAST_REG=3, values 0xF0,0x0F,0xFF -> 3 beats then a sum beat with data 0x00, out_sum=1 and out_last=1.
REQ-036 Reset mid-dump: assert reset during beat index 10 -> next cycle out_valid=0, busy=0 and no done pulse; a new start restarts at index FIRST_REG.
REQ-037 Ignored start: pulse start while busy at index 5 -> dump continues unchanged with exactly one done pulse; a FIRST_REG=LAST_REG=7 build yields a single beat with out_last=1 (macro undefined).
